// File: rtl/ip_match_table.sv
// rtl/ip_match_table.sv - sliding-window multi-entry masked key matcher for the receive stream
// Window holds KEY_BYTES+BYTES-1 bytes, newest byte in the low byte lane.
module ip_match_table #(
  parameter int BYTES       = 4,
  parameter int KEY_BYTES   = 4,
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     data_valid,
  input  logic [8*BYTES-1:0]       data_in,
  input  logic                     prog_we,
  input  logic [IDX_W-1:0]         prog_idx,
  input  logic [8*KEY_BYTES-1:0]   prog_key,
  input  logic [KEY_BYTES-1:0]     prog_mask,
  input  logic                     prog_en,
  output logic [8*BYTES-1:0]       data_out,
  output logic                     data_out_valid,
  output logic                     match,
  output logic [NUM_ENTRIES-1:0]   match_vec,
  output logic [IDX_W-1:0]         match_idx
);

  localparam int WIN   = KEY_BYTES + BYTES - 1;
  localparam int SAT   = KEY_BYTES + BYTES;
  localparam int CNT_W = $clog2(SAT + 1);

  logic [8*WIN-1:0]         r_win;
  logic [CNT_W-1:0]         r_cnt;
  logic [8*BYTES-1:0]       r_d1;
  logic                     r_v1;
  logic [8*BYTES-1:0]       r_dout;
  logic                     r_dv;
  logic [NUM_ENTRIES-1:0]   r_vec;
  logic [IDX_W-1:0]         r_idx;

  logic [8*KEY_BYTES-1:0]   r_key  [NUM_ENTRIES];
  logic [KEY_BYTES-1:0]     r_mask [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]   r_en;

  logic                     w_acc;
  logic [8*WIN-1:0]         w_win_next;
  logic [NUM_ENTRIES-1:0]   w_hit;
  logic [IDX_W-1:0]         w_first;
  logic                     w_eq;

  assign w_acc = data_valid & ~clear;

  generate
    if (KEY_BYTES > 1) begin : g_shift
      assign w_win_next = {r_win[8*(KEY_BYTES-1)-1:0], data_in};
    end else begin : g_noshift
      assign w_win_next = data_in;
    end
  endgenerate

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_win <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_win <= '0;
      r_cnt <= '0;
    end else if (w_acc) begin
      r_win <= w_win_next;
      // saturate once every candidate is eligible
      if (r_cnt >= CNT_W'(SAT - BYTES)) r_cnt <= CNT_W'(SAT);
      else                              r_cnt <= r_cnt + CNT_W'(BYTES);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_d1   <= '0;
      r_v1   <= 1'b0;
      r_dout <= '0;
      r_dv   <= 1'b0;
    end else if (clear) begin
      r_d1   <= '0;
      r_v1   <= 1'b0;
      r_dout <= '0;
      r_dv   <= 1'b0;
    end else begin
      r_d1   <= data_in;
      r_v1   <= data_valid;
      r_dout <= r_d1;
      r_dv   <= r_v1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_en <= '0;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        r_key[e]  <= '0;
        r_mask[e] <= '0;
      end
    end else if (prog_we) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (prog_idx == IDX_W'(e)) begin
          r_key[e]  <= prog_key;
          r_mask[e] <= prog_mask;
          r_en[e]   <= prog_en;
        end
      end
    end
  end

  // Candidate k is the key-sized field ending k bytes before the newest byte.
  always_comb begin
    w_hit = '0;
    w_eq  = 1'b0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      for (int k = 0; k < BYTES; k++) begin
        w_eq = 1'b1;
        for (int b = 0; b < KEY_BYTES; b++) begin
          if (r_mask[e][b] && (r_win[8*(k+b) +: 8] != r_key[e][8*b +: 8])) w_eq = 1'b0;
        end
        if (r_en[e] && w_eq && (r_cnt >= CNT_W'(KEY_BYTES + k))) w_hit[e] = 1'b1;
      end
    end
  end

  always_comb begin
    w_first = '0;
    for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
      if (w_hit[e]) w_first = IDX_W'(e);
    end
  end

  // r_v1 marks a cycle whose window was just refreshed by an accepted word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_vec <= '0;
      r_idx <= '0;
    end else if (clear) begin
      r_vec <= '0;
      r_idx <= '0;
    end else if (r_v1) begin
      r_vec <= r_vec | w_hit;
      if (!(|r_vec) && (|w_hit)) r_idx <= w_first;
    end
  end

  assign data_out       = r_dout;
  assign data_out_valid = r_dv;
  assign match_vec      = r_vec;
  assign match          = |r_vec;
  assign match_idx      = r_idx;

endmodule

// File: tb/tb_ip_match_table.sv
// tb/tb_ip_match_table.sv - table-driven scoreboard bench for ip_match_table
module tb_ip_match_table;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        clear = 1'b0;
  logic        data_valid = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic        prog_we = 1'b0;
  logic [1:0]  prog_idx = 2'd0;
  logic [31:0] prog_key = 32'h0;
  logic [3:0]  prog_mask = 4'h0;
  logic        prog_en = 1'b0;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic        match;
  logic [3:0]  match_vec;
  logic [1:0]  match_idx;

  ip_match_table #(.BYTES(4), .KEY_BYTES(4), .NUM_ENTRIES(4), .IDX_W(2)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .data_valid(data_valid), .data_in(data_in),
    .prog_we(prog_we), .prog_idx(prog_idx), .prog_key(prog_key), .prog_mask(prog_mask),
    .prog_en(prog_en), .data_out(data_out), .data_out_valid(data_out_valid),
    .match(match), .match_vec(match_vec), .match_idx(match_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pwe;
    logic [1:0]  pidx;
    logic [31:0] pkey;
    logic [3:0]  pmask;
    logic        pen;
    logic        clr;
    logic        vld;
    logic [31:0] data;
    logic [3:0]  ev;
    logic [1:0]  ei;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  ev;
    logic [1:0]  ei;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  logic last_pushed = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic pwe, logic [1:0] pidx, logic [31:0] pkey, logic [3:0] pmask,
                              logic pen, logic clr, logic vld, logic [31:0] data,
                              logic [3:0] ev, logic [1:0] ei);
    vec_t v;
    v.pwe = pwe; v.pidx = pidx; v.pkey = pkey; v.pmask = pmask; v.pen = pen;
    v.clr = clr; v.vld = vld; v.data = data; v.ev = ev; v.ei = ei;
    return v;
  endfunction

  function automatic vec_t row_p(logic [1:0] idx, logic [31:0] key, logic [3:0] mask, logic en);
    return mk(1'b1, idx, key, mask, en, 1'b0, 1'b0, 32'h0, 4'h0, 2'd0);
  endfunction

  function automatic vec_t row_c();
    return mk(1'b0, 2'd0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 2'd0);
  endfunction

  function automatic vec_t row_w(logic [31:0] data, logic [3:0] ev, logic [1:0] ei);
    return mk(1'b0, 2'd0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, data, ev, ei);
  endfunction

  function automatic vec_t row_i();
    return mk(1'b0, 2'd0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 2'd0);
  endfunction

  task automatic apply(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    prog_we = v.pwe; prog_idx = v.pidx; prog_key = v.pkey; prog_mask = v.pmask; prog_en = v.pen;
    clear = v.clr; data_valid = v.vld; data_in = v.data;
    // the word accepted one edge earlier is still in the pipeline and is dropped by this clear
    if (v.clr && last_pushed && sb.size() > 0) void'(sb.pop_back());
    last_pushed = v.vld && !v.clr;
    if (last_pushed) begin
      e.data = v.data; e.ev = v.ev; e.ei = v.ei;
      sb.push_back(e);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data_out"}, data_out, 32'h0);
    chk({tag, "_dov"}, 32'(data_out_valid), 32'h0);
    chk({tag, "_match"}, 32'(match), 32'h0);
    chk({tag, "_match_vec"}, 32'(match_vec), 32'h0);
    chk({tag, "_match_idx"}, 32'(match_idx), 32'h0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (n_rst === 1'b1 && data_out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output got=%h want=no_word", data_out);
      end else begin
        e = sb.pop_front();
        chk("data_out", data_out, e.data);
        chk("match_vec", 32'(match_vec), 32'(e.ev));
        chk("match_idx", 32'(match_idx), 32'(e.ei));
        chk("match", 32'(match), 32'(|e.ev));
      end
    end
  end

  initial begin
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    #2 chk_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #2 n_rst = 1'b1;

    // aligned hit
    tbl.push_back(row_p(2'd0, 32'hC0A80001, 4'hF, 1'b1));
    tbl.push_back(row_c());
    tbl.push_back(row_w(32'h11223344, 4'h0, 2'd0));
    tbl.push_back(row_w(32'hC0A80001, 4'h1, 2'd0));
    tbl.push_back(row_i()); tbl.push_back(row_i());
    // straddle, k=2
    tbl.push_back(row_c());
    tbl.push_back(row_w(32'h1122C0A8, 4'h0, 2'd0));
    tbl.push_back(row_w(32'h00013344, 4'h1, 2'd0));
    tbl.push_back(row_w(32'h55667788, 4'h1, 2'd0));
    tbl.push_back(row_i()); tbl.push_back(row_i());
    // idle cycles between words
    tbl.push_back(row_c());
    tbl.push_back(row_w(32'h11223344, 4'h0, 2'd0));
    tbl.push_back(row_i()); tbl.push_back(row_i()); tbl.push_back(row_i());
    tbl.push_back(row_w(32'hC0A80001, 4'h1, 2'd0));
    tbl.push_back(row_i()); tbl.push_back(row_i());
    // warm-up guard
    tbl.push_back(row_p(2'd0, 32'h00000000, 4'hF, 1'b1));
    tbl.push_back(row_c());
    tbl.push_back(row_w(32'h00000011, 4'h0, 2'd0));
    tbl.push_back(row_w(32'h00000000, 4'h1, 2'd0));
    tbl.push_back(row_i()); tbl.push_back(row_i());
    // masks, multiple entries, first index frozen
    tbl.push_back(row_p(2'd0, 32'h00000000, 4'h0, 1'b0));
    tbl.push_back(row_p(2'd1, 32'h0A000000, 4'h8, 1'b1));
    tbl.push_back(row_p(2'd3, 32'hC0A80001, 4'hF, 1'b1));
    tbl.push_back(row_c());
    tbl.push_back(row_w(32'h0AC0A800, 4'h2, 2'd1));
    tbl.push_back(row_w(32'h01FFFFFF, 4'hA, 2'd1));
    tbl.push_back(row_i()); tbl.push_back(row_i());
    // entry2 written during the compare of its completing word, then frame resent
    tbl.push_back(row_c());
    tbl.push_back(row_w(32'h11223344, 4'h0, 2'd0));
    tbl.push_back(row_w(32'hDEADBEEF, 4'h0, 2'd0));
    tbl.push_back(row_p(2'd2, 32'hDEADBEEF, 4'hF, 1'b1));
    tbl.push_back(row_i()); tbl.push_back(row_i());
    tbl.push_back(row_c());
    tbl.push_back(row_w(32'h11223344, 4'h0, 2'd0));
    tbl.push_back(row_w(32'hDEADBEEF, 4'h4, 2'd2));
    tbl.push_back(row_i()); tbl.push_back(row_i());

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // clear in the same cycle as the completing word
    apply(row_c());
    apply(row_w(32'h11223344, 4'h0, 2'd0));
    apply(mk(1'b0, 2'd0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 4'h0, 2'd0));
    for (int i = 0; i < 3; i++) begin
      apply(row_i());
      chk("clr_word_dov", 32'(data_out_valid), 32'h0);
      chk("clr_word_match", 32'(match), 32'h0);
    end

    // async reset after a hit wipes the table too
    apply(row_c());
    apply(row_w(32'h11223344, 4'h0, 2'd0));
    apply(row_w(32'hDEADBEEF, 4'h4, 2'd2));
    apply(row_i());
    apply(row_i());
    @(posedge clk);
    #3 n_rst = 1'b0;
    #1 chk_zero("midrst");
    sb.delete();
    last_pushed = 1'b0;
    @(posedge clk);
    #2 n_rst = 1'b1;
    apply(row_c());
    apply(row_w(32'h11223344, 4'h0, 2'd0));
    apply(row_w(32'hDEADBEEF, 4'h0, 2'd0));
    for (int i = 0; i < 4; i++) apply(row_i());
    chk("post_rst_match", 32'(match), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ip_match_table.md
# ip_match_table

Parametrised multi-entry IP/field matcher for the Ethernet sniffer datapath. It sits inline on the byte-packed receive stream and compares a sliding byte window against NUM_ENTRIES host-programmed keys, each with a byte mask, at every byte alignment. It reports sticky per-entry hits and the index of the first entry hit. Matches are suppressed until enough bytes of the current frame have been received, so bytes left over from before a clear can never produce a hit.

## Interface
- BYTES, 4: bytes per data word; must be ≥1.
- KEY_BYTES, 4: key length in bytes (4 for IPv4, 16 for IPv6, 2 for ports); must be ≥1.
- NUM_ENTRIES, 4: number of programmable keys; must be ≥1.
- IDX_W, max(1,$clog2(NUM_ENTRIES)): entry index width.
- clk  in  1  system clock; all state changes on its rising edge.
- n_rst  in  1  asynchronous active-low reset.
- clear  in  1  synchronous frame-start clear; wins over data_valid.
- data_valid  in  1  data_in carries a word this cycle.
- data_in  in  8*BYTES  stream word; bits [8*BYTES-1 -: 8] hold the earliest byte on the wire.
- prog_we  in  1  write a table entry.
- prog_idx  in  IDX_W  entry to write; values ≥NUM_ENTRIES are ignored.
- prog_key  in  8*KEY_BYTES  key; MSB byte is the earliest.
- prog_mask  in  KEY_BYTES  per-byte compare enable; bit KEY_BYTES-1 maps to the MSB byte.
- prog_en  in  1  entry enable written with the key.
- data_out  out  8*BYTES  data_in delayed 2 cycles.
- data_out_valid  out  1  data_valid delayed 2 cycles.
- match  out  1  OR of match_vec.
- match_vec  out  NUM_ENTRIES  sticky per-entry hit flags.
- match_idx  out  IDX_W  lowest-index entry among the first hit event; frozen until clear.

## Operation
- Window: shift register of WIN = KEY_BYTES+BYTES-1 bytes. On each accepted word, all BYTES bytes shift in; the oldest bytes fall out.
- bytes_seen: saturating counter, ≥ WIN+1 capacity. Reset/clear → 0. Adds BYTES per accepted word. Counts bytes received since the last clear, including the newest word.
- Candidate k, for k = 0..BYTES-1, is the KEY_BYTES-byte field ending k bytes before the newest byte.
- Candidate k is eligible only when bytes_seen ≥ KEY_BYTES+k.
- Entry e hits candidate k when all of these hold:
  - entry e is enabled;
  - for every byte with its prog_mask bit set, the window byte equals the key byte (masked-out bytes always compare true);
  - candidate k is eligible.
- An entry with an all-zero mask hits any eligible candidate.
- Compare stage: the hit vector is evaluated from the registered window and registered only in a cycle where the window was updated by an accepted word. It ORs into match_vec.
- match_idx loads the lowest set bit of the new hit vector only when match was 0 before that cycle.
- Table: prog_we writes key, mask and enable on the clock edge. The write is used by compares from the next cycle on. Table contents survive clear; reset disables all entries and zeroes keys and masks.
- clear zeroes the window, bytes_seen, match_vec, match_idx, data_out and data_out_valid. It discards any word presented in the same cycle.

## Timing
- Reset values: data_out=0, data_out_valid=0, match=0, match_vec=0, match_idx=0.
- Word accepted at edge t (data_valid=1, clear=0):
  - window and bytes_seen update at edge t;
  - data_out, data_out_valid and match_vec update at edge t+1.
- A hit is therefore visible in the same cycle that data_out shows the word completing the key.
- Idle cycles (data_valid=0): window frozen; data_out_valid=0 two cycles later; no new hits.
- Clear asserted at edge t: all listed state is 0 after edge t. Words accepted before the clear still in the pipeline are dropped, with no late hits.
- A prog_we in the same cycle as a compare affects only later compares.
- Asynchronous n_rst mid-frame: all state, including the table, goes to reset values immediately.

## Test plan
- Aligned hit: BYTES=4, entry0 key C0A80001, mask F, enabled; clear; words 11223344, C0A80001 → match_vec=0001, match_idx=0, asserted with data_out=C0A80001, 2 cycles after the second word.
- Straddle: same entry; words 1122C0A8, 00013344 → match with the second word (k=2); a third word 55667788 keeps match=1.
- Warm-up guard: entry0 key 00000000, mask F; clear; word 00000011 → no match; next word 00000000 → match.
- Mask, multiple entries, first index: entry1 key 0A000000 mask 8; entry3 key C0A80001 mask F; words 0AC0A800, 01FFFFFF → after word 1 match_vec=0010, match_idx=1; after word 2 match_vec=1010, match_idx still 1.
- Stalls, clear and reset: repeat the aligned case with 3 idle cycles between words → hit still occurs. clear in the same cycle as word C0A80001 → no hit, data_out_valid stays 0. n_rst pulse after the hit → outputs 0, and after re-streaming with no reprogramming, no hit occurs.
- Reprogramming: write entry2 in the same cycle as the completing word → no hit; resend the frame → hit on entry2.
